alu_fun_arbiter: RTL

Round-robin issuer that sits in front of the 16-bit ALU and drives its 2-bit `ALU_FUN` select. Four requesters (arithmetic, logic, compare, shift) raise level requests. The block grants one at a time and encodes the winner into `ALU_FUN` with a one-cycle issue pulse. It then waits for the ALU's result-valid, or a timeout, and returns a one-cycle acknowledge to the winner.

---
 rtl/alu_fun_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_fun_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_fun_arbiter
// Description : Round-robin issuer driving the ALU_FUN select for four
//               requesters, with result-valid / timeout completion and Ack.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_fun_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Req,
    input  logic       ALU_OUT_VALID,
    output logic [1:0] ALU_FUN,
    output logic       ALU_Issue,
    output logic [3:0] Grant,
    output logic [3:0] Ack,
    output logic       Timeout_Err,
    output logic       Busy
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] fun_q, fun_d;
    logic       issue_q, issue_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] ack_q, ack_d;
    logic       terr_q, terr_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Search starts one past the last-served requester and wraps modulo 4.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fun_d   = fun_q;
        issue_d = issue_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        terr_d  = terr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_ISSUE;
                    grant_d = 4'b0001 << win_idx;
                    fun_d   = win_idx;
                    issue_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                issue_d = 1'b0;
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid on the same edge as the timeout takes precedence.
                if (ALU_OUT_VALID) begin
                    state_d = ST_DONE;
                    ack_d   = grant_q;
                    terr_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == C_TIMEOUT) begin
                        state_d = ST_DONE;
                        ack_d   = grant_q;
                        terr_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                grant_d = 4'd0;
                ack_d   = 4'd0;
                busy_d  = 1'b0;
                terr_d  = 1'b0;
                last_d  = fun_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            fun_q   <= 2'd0;
            issue_q <= 1'b0;
            grant_q <= 4'd0;
            ack_q   <= 4'd0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            fun_q   <= fun_d;
            issue_q <= issue_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign ALU_FUN     = fun_q;
    assign ALU_Issue   = issue_q;
    assign Grant       = grant_q;
    assign Ack         = ack_q;
    assign Timeout_Err = terr_q;
    assign Busy        = busy_q;

endmodule
`default_nettype wire
